wavetable_voice_sequencer: RTL and testbench
============================================

// Module: wavetable_voice_sequencer
// PURPOSE
//  Time-multiplexes one 512x16 wavetable RAM (RAM_512x16_organ-style port) among NV voices.
//  Each sample_tick: read one table entry per voice at its phase, convert to signed, mix, emit one sample.
//  Owns all RAM control; a host load port can write the table only while the sequencer is idle.
//  Sits between the note/parameter control logic and the output DAC/PWM stage.
// PARAMETERS
//  NV       4   number of voices; power of 2, 2..16
//  PHASE_W  24  phase accumulator width; RAM address = phase[PHASE_W-1 -: 9]
// PORTS
//  clk          in   1        system clock
//  rst          in   1        synchronous, active-high reset
//  sample_tick  in   1        1-cycle pulse: start one sample computation
//  gate         in   NV       per-voice enable; low = voice silent, phase held at 0
//  inc_we       in   1        write phase increment
//  inc_voice    in   log2(NV) voice index for inc_we
//  inc_data     in   PHASE_W  phase increment value
//  ld_valid     in   1        host table write request
//  ld_addr      in   9        host table write address
//  ld_data      in   16       host table write data
//  ld_ready     out  1        host write accepted this cycle when ld_valid&ld_ready
//  ram_addr     out  9        to RAM ram_addr
//  ram_wdata    out  16       to RAM ram_wdata
//  ram_ce       out  1        to RAM ce
//  ram_we       out  1        to RAM we
//  ram_re       out  1        to RAM re
//  ram_rdata    in   16       from RAM; valid 1 cycle after ram_re (registered read)
//  sample_out   out  16       signed mixed sample
//  sample_valid out  1        1-cycle pulse, sample_out updated
//  busy         out  1        high from accepted tick until sample_valid inclusive
//  overrun      out  1        1-cycle pulse: sample_tick arrived while busy (tick dropped)
// BEHAVIOUR
//  - Reset: all outputs 0, ld_ready 0 during rst; phase[]=0, inc[]=0, state IDLE, acc=0.
//  - FSM: IDLE -> ISSUE(v) -> CAPTURE(v) -> ISSUE(v+1) ... CAPTURE(NV-1) -> OUT -> IDLE.
//  - IDLE + sample_tick: v=0, acc=0, go ISSUE. Tick ignored (overrun pulse) in any other state.
//  - ISSUE(v): ram_ce=1, ram_re=1, ram_we=0, ram_addr=phase[v][PHASE_W-1 -: 9].
//  - CAPTURE(v): s = {~ram_rdata[15], ram_rdata[14:0]} (offset-binary -> signed);
//    if gate[v] acc += sext(s) else acc unchanged; phase[v] = gate[v] ? phase[v]+inc[v] : 0 (mod 2^PHASE_W, wraps).
//  - OUT: sample_out = acc >>> log2(NV) (acc is 16+log2(NV) bits signed, no saturation needed); sample_valid=1.
//  - Latency: tick cycle T -> sample_valid at T+2*NV+1. Busy for 2*NV+1 cycles after the tick.
//  - Host load: ld_ready = (state==IDLE) & ~sample_tick & ~rst. On ld_valid&ld_ready, same cycle:
//    ram_ce=1, ram_we=1, ram_re=0, ram_addr=ld_addr, ram_wdata=ld_data. Tick wins over load in same cycle.
//  - inc_we: inc[inc_voice] <= inc_data any cycle; used at that voice's next CAPTURE (may be this sample).
//  - gate sampled per voice at its CAPTURE cycle; gate rising => first read at address 0.
//  - Idle RAM controls: ce=re=we=0; ram_addr/ram_wdata don't-care but held stable.
//  - rst mid-computation: abort, no sample_valid, all state to reset values.
// STRUCTURE
//  - synth_pkg: NV/PHASE_W defaults, state enum (IDLE/ISSUE/CAPTURE/OUT), function off2s(16b)->signed 16b.
//  - Sub-module voice_phase_bank: inc[] and phase[] registers, write port (inc_we) and
//    indexed read/update port (v, gate, advance); top holds FSM, arbitration and mixer.
// TESTING
//  1. Reset: hold rst 3 cycles -> all outputs 0, ld_ready 0; release -> ld_ready 1, busy 0.
//  2. Load: write addr0=0xFFFF, addr1=0x8000, addr2=0x0000 via ld port -> ram_we pulses, ld_ready 1 each cycle.
//  3. Single voice: NV=4, gate=4'b0001, inc[0]=0x008000; 3 ticks -> sample_out 0x1FFF, 0x0000, 0xE000;
//     sample_valid exactly 9 cycles after each tick; ram_addr 0,1,2.
//  4. All voices gated, each inc=0, table[0]=0xFFFF -> sample_out 0x7FFF; voice 3 ungated -> 0x5FFF.
//  5. Tick while busy -> overrun pulse, single sample_valid; ld_valid during busy -> ld_ready 0, no ram_we.
//  6. Wrap: inc[0]=0xFF8000 from phase 0 -> addresses 0,511,510; rst asserted mid-sample -> no sample_valid.

Source files
------------

// File: rtl/wavetable_voice_sequencer_pkg.sv
// Shared constants, FSM state type and sample conversion helper for the
// wavetable voice sequencer.
package wavetable_voice_sequencer_pkg;

    localparam int NV_DEFAULT      = 4;
    localparam int PHASE_W_DEFAULT = 24;
    localparam int ADDR_W          = 9;
    localparam int DATA_W          = 16;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_OUT     = 2'd3
    } seq_state_e;

    // Table entries are offset-binary; flipping the MSB gives two's complement.
    function automatic logic signed [DATA_W-1:0] off2s(input logic [DATA_W-1:0] d);
        return {~d[DATA_W-1], d[DATA_W-2:0]};
    endfunction

endpackage

// File: rtl/wavetable_voice_sequencer_voice_phase_bank.sv
// Per-voice phase increment and phase accumulator registers.
// One write port for increments, one indexed read/advance port used by the sequencer.
module wavetable_voice_sequencer_voice_phase_bank
#(
    parameter int NV      = 4,
    parameter int PHASE_W = 24,
    localparam int VW     = $clog2(NV)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               inc_we,
    input  logic [VW-1:0]      inc_voice,
    input  logic [PHASE_W-1:0] inc_data,
    input  logic [VW-1:0]      rd_voice,
    input  logic               adv_en,
    input  logic               adv_gate,
    output logic [PHASE_W-1:0] rd_phase
);

    logic [PHASE_W-1:0] phase_vec [NV];

    for (genvar gi = 0; gi < NV; gi++) begin : g_voice
        logic [PHASE_W-1:0] inc_reg;
        logic [PHASE_W-1:0] phase_reg;

        // Increment write and phase advance; an ungated voice parks at phase 0
        // so its first read after gating on is table address 0.
        always_ff @(posedge clk) begin
            if (rst) begin
                inc_reg   <= '0;
                phase_reg <= '0;
            end else begin
                if (inc_we && (inc_voice == VW'(gi))) begin
                    inc_reg <= inc_data;
                end
                if (adv_en && (rd_voice == VW'(gi))) begin
                    phase_reg <= adv_gate ? (phase_reg + inc_reg) : '0;
                end
            end
        end

        assign phase_vec[gi] = phase_reg;
    end

    assign rd_phase = phase_vec[rd_voice];

endmodule

// File: rtl/wavetable_voice_sequencer.sv
// Time-multiplexes a single 512x16 wavetable RAM across NV voices: one read per
// voice per sample tick, offset-binary to signed conversion, mixing and scaling.
// Host table writes are only granted while the sequencer is idle.
module wavetable_voice_sequencer
    import wavetable_voice_sequencer_pkg::*;
#(
    parameter int NV      = NV_DEFAULT,
    parameter int PHASE_W = PHASE_W_DEFAULT,
    localparam int VW     = $clog2(NV),
    localparam int ACC_W  = DATA_W + VW
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               sample_tick,
    input  logic [NV-1:0]      gate,
    input  logic               inc_we,
    input  logic [VW-1:0]      inc_voice,
    input  logic [PHASE_W-1:0] inc_data,
    input  logic               ld_valid,
    input  logic [ADDR_W-1:0]  ld_addr,
    input  logic [DATA_W-1:0]  ld_data,
    output logic               ld_ready,
    output logic [ADDR_W-1:0]  ram_addr,
    output logic [DATA_W-1:0]  ram_wdata,
    output logic               ram_ce,
    output logic               ram_we,
    output logic               ram_re,
    input  logic [DATA_W-1:0]  ram_rdata,
    output logic [DATA_W-1:0]  sample_out,
    output logic               sample_valid,
    output logic               busy,
    output logic               overrun
);

    seq_state_e                state_reg;
    logic [VW-1:0]             voice_reg;
    logic signed [ACC_W-1:0]   acc_reg;
    logic [DATA_W-1:0]         sample_out_reg;
    logic                      sample_valid_reg;
    logic                      overrun_reg;
    logic [ADDR_W-1:0]         addr_hold_reg;
    logic [DATA_W-1:0]         wdata_hold_reg;

    logic [PHASE_W-1:0]        cur_phase;
    logic                      issue;
    logic                      ld_fire;
    logic                      cur_gate;
    logic signed [DATA_W-1:0]  s_val;
    logic signed [ACC_W-1:0]   acc_sum;
    logic signed [ACC_W-1:0]   mix_shift;

    wavetable_voice_sequencer_voice_phase_bank #(
        .NV      (NV),
        .PHASE_W (PHASE_W)
    ) u_phase_bank (
        .clk       (clk),
        .rst       (rst),
        .inc_we    (inc_we),
        .inc_voice (inc_voice),
        .inc_data  (inc_data),
        .rd_voice  (voice_reg),
        .adv_en    (state_reg == ST_CAPTURE),
        .adv_gate  (cur_gate),
        .rd_phase  (cur_phase)
    );

    // RAM arbitration: sequencer reads in ISSUE, host writes only when idle with no tick.
    always_comb begin
        issue     = (state_reg == ST_ISSUE) && !rst;
        ld_ready  = (state_reg == ST_IDLE) && !sample_tick && !rst;
        ld_fire   = ld_valid && ld_ready;
        ram_ce    = issue || ld_fire;
        ram_re    = issue;
        ram_we    = ld_fire;
        ram_addr  = addr_hold_reg;
        ram_wdata = wdata_hold_reg;
        if (rst) begin
            ram_addr  = '0;
            ram_wdata = '0;
        end else if (issue) begin
            ram_addr = cur_phase[PHASE_W-1 -: ADDR_W];
        end else if (ld_fire) begin
            ram_addr  = ld_addr;
            ram_wdata = ld_data;
        end
    end

    // Mixer datapath for the voice being captured this cycle.
    always_comb begin
        cur_gate  = gate[voice_reg];
        s_val     = off2s(ram_rdata);
        acc_sum   = cur_gate ? (acc_reg + {{VW{s_val[DATA_W-1]}}, s_val}) : acc_reg;
        mix_shift = acc_sum >>> VW;
    end

    // Keep RAM address/data stable while the RAM is not being accessed.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_hold_reg  <= '0;
            wdata_hold_reg <= '0;
        end else begin
            addr_hold_reg  <= ram_addr;
            wdata_hold_reg <= ram_wdata;
        end
    end

    // Sequencer FSM: ISSUE/CAPTURE per voice, then one OUT cycle with the mixed sample.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg        <= ST_IDLE;
            voice_reg        <= '0;
            acc_reg          <= '0;
            sample_out_reg   <= '0;
            sample_valid_reg <= 1'b0;
            overrun_reg      <= 1'b0;
        end else begin
            sample_valid_reg <= 1'b0;
            overrun_reg      <= sample_tick && (state_reg != ST_IDLE);
            case (state_reg)
                ST_IDLE: begin
                    if (sample_tick) begin
                        voice_reg <= '0;
                        acc_reg   <= '0;
                        state_reg <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    state_reg <= ST_CAPTURE;
                end
                ST_CAPTURE: begin
                    acc_reg <= acc_sum;
                    if (voice_reg == VW'(NV - 1)) begin
                        sample_out_reg   <= mix_shift[DATA_W-1:0];
                        sample_valid_reg <= 1'b1;
                        state_reg        <= ST_OUT;
                    end else begin
                        voice_reg <= voice_reg + 1'b1;
                        state_reg <= ST_ISSUE;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign sample_out   = sample_out_reg;
    assign sample_valid = sample_valid_reg;
    assign overrun      = overrun_reg;
    assign busy         = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_wavetable_voice_sequencer.sv
// Self-checking bench for wavetable_voice_sequencer: RAM environment, phase/mix
// model feeding a scoreboard of expected samples and read addresses.
module tb_wavetable_voice_sequencer;

    localparam int NV = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sample_tick = 1'b0;
    logic [3:0]  gate = '0;
    logic        inc_we = 1'b0;
    logic [1:0]  inc_voice = '0;
    logic [23:0] inc_data = '0;
    logic        ld_valid = 1'b0;
    logic [8:0]  ld_addr = '0;
    logic [15:0] ld_data = '0;
    logic        ld_ready;
    logic [8:0]  ram_addr;
    logic [15:0] ram_wdata;
    logic        ram_ce, ram_we, ram_re;
    logic [15:0] ram_rdata = '0;
    logic [15:0] sample_out;
    logic        sample_valid, busy, overrun;

    wavetable_voice_sequencer dut (
        .clk(clk), .rst(rst), .sample_tick(sample_tick), .gate(gate),
        .inc_we(inc_we), .inc_voice(inc_voice), .inc_data(inc_data),
        .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data), .ld_ready(ld_ready),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_ce(ram_ce), .ram_we(ram_we),
        .ram_re(ram_re), .ram_rdata(ram_rdata), .sample_out(sample_out),
        .sample_valid(sample_valid), .busy(busy), .overrun(overrun)
    );

    always #5 clk = ~clk;

    // RAM environment: registered read, write on ce&we
    logic [15:0] mem [512];
    always @(posedge clk) begin
        if (ram_ce && ram_we) mem[ram_addr] <= ram_wdata;
        if (ram_ce && ram_re) ram_rdata <= mem[ram_addr];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Bench model state
    logic [15:0] table_img [512];
    logic [23:0] phase_m [NV];
    logic [23:0] inc_m [NV];

    typedef struct { logic [15:0] sample; int tick_cyc; } exp_t;
    exp_t        exp_q[$];
    logic [8:0]  addr_q[$];
    bit          chk_addr = 1'b1;
    int          n_valid = 0;
    int          n_overrun = 0;

    int n_compared = 0;
    int n_mismatched = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Output monitor: compare read addresses and samples against the scoreboard
    always @(negedge clk) begin
        if (ram_ce && ram_re && chk_addr) begin
            if (addr_q.size() == 0) chk("rd_addr_unexpected", 32'd1, 32'd0);
            else chk("rd_addr", 32'(ram_addr), 32'(addr_q.pop_front()));
        end
        if (sample_valid === 1'b1) begin
            n_valid++;
            if (exp_q.size() == 0) begin
                chk("sample_unexpected", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                $display("sample at cycle %0d: out=0x%04h expected=0x%04h", cyc, sample_out, e.sample);
                chk("sample_out", 32'(sample_out), 32'(e.sample));
                chk("latency", 32'(cyc - e.tick_cyc), 32'd9);
            end
        end
        if (overrun === 1'b1) n_overrun++;
    end

    task automatic model_tick();
        int acc;
        logic [8:0] a;
        logic signed [15:0] sv;
        exp_t e;
        acc = 0;
        for (int v = 0; v < NV; v++) begin
            a = phase_m[v][23:15];
            addr_q.push_back(a);
            if (gate[v]) begin
                sv = {~table_img[a][15], table_img[a][14:0]};
                acc += sv;
                phase_m[v] = phase_m[v] + inc_m[v];
            end else begin
                phase_m[v] = '0;
            end
        end
        acc = acc >>> 2;
        e.sample = acc[15:0];
        e.tick_cyc = cyc;
        exp_q.push_back(e);
    endtask

    task automatic do_tick();
        @(posedge clk); #1;
        sample_tick = 1'b1;
        model_tick();
        @(posedge clk); #1;
        sample_tick = 1'b0;
    endtask

    task automatic wait_done();
        int budget;
        budget = 40;
        while (exp_q.size() != 0 && budget > 0) begin
            @(posedge clk);
            budget--;
        end
        #1;
        if (exp_q.size() != 0) begin
            chk("sample_timeout", 32'(exp_q.size()), 32'd0);
            exp_q.delete();
        end
        chk("addr_leftover", 32'(addr_q.size()), 32'd0);
        addr_q.delete();
        @(posedge clk); #1;
    endtask

    task automatic set_inc(input int v, input logic [23:0] val);
        @(posedge clk); #1;
        inc_we = 1'b1; inc_voice = 2'(v); inc_data = val;
        inc_m[v] = val;
        @(posedge clk); #1;
        inc_we = 1'b0;
    endtask

    logic [8:0]  ld_addrs [5] = '{9'd0, 9'd1, 9'd2, 9'd511, 9'd510};
    logic [15:0] ld_datas [5] = '{16'hFFFF, 16'h8000, 16'h0000, 16'hC000, 16'h4000};

    initial begin
        int v0, o0;
        for (int i = 0; i < 512; i++) begin
            mem[i] = '0;
            table_img[i] = '0;
        end
        for (int v = 0; v < NV; v++) begin
            phase_m[v] = '0;
            inc_m[v] = '0;
        end

        // 1. Reset
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_ctrl", {sample_valid, busy, overrun, ld_ready, ram_ce, ram_we, ram_re, ram_addr}, 32'd0);
            chk("rst_data", {sample_out, ram_wdata}, 32'd0);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("ld_ready_after_rst", 32'(ld_ready), 32'd1);
        chk("busy_after_rst", 32'(busy), 32'd0);

        // 2. Host load, back to back
        @(posedge clk); #1;
        for (int i = 0; i < 5; i++) begin
            ld_valid = 1'b1; ld_addr = ld_addrs[i]; ld_data = ld_datas[i];
            table_img[ld_addrs[i]] = ld_datas[i];
            @(negedge clk);
            $display("load addr=%0d data=0x%04h ready=%0b we=%0b", ld_addr, ld_data, ld_ready, ram_we);
            chk("ld_ready", 32'(ld_ready), 32'd1);
            chk("ld_we", {ram_ce, ram_we, ram_re}, 32'b110);
            chk("ld_addr", 32'(ram_addr), 32'(ld_addrs[i]));
            chk("ld_wdata", 32'(ram_wdata), 32'(ld_datas[i]));
            @(posedge clk); #1;
        end
        ld_valid = 1'b0;

        // 3. Single voice, inc 0x008000 -> addresses 0,1,2
        gate = 4'b0001;
        set_inc(0, 24'h008000);
        for (int i = 0; i < 3; i++) begin
            do_tick();
            wait_done();
        end

        // 4. All voices gated at phase 0 with zero increments
        gate = 4'b0000;
        set_inc(0, 24'h000000);
        do_tick(); wait_done();
        gate = 4'b1111;
        do_tick(); wait_done();
        gate = 4'b0111;
        do_tick(); wait_done();

        // 5. Tick while busy, and host load while busy
        gate = 4'b1111;
        v0 = n_valid; o0 = n_overrun;
        do_tick();
        sample_tick = 1'b1;
        @(posedge clk); #1;
        sample_tick = 1'b0;
        ld_valid = 1'b1; ld_addr = 9'd5; ld_data = 16'h1234;
        @(negedge clk);
        chk("busy_during_sample", 32'(busy), 32'd1);
        chk("ld_ready_busy", 32'(ld_ready), 32'd0);
        chk("ram_we_busy", 32'(ram_we), 32'd0);
        @(posedge clk); #1;
        ld_valid = 1'b0;
        wait_done();
        repeat (12) @(posedge clk);
        #1;
        chk("overrun_count", 32'(n_overrun - o0), 32'd1);
        chk("valid_count", 32'(n_valid - v0), 32'd1);
        chk("mem5_untouched", 32'(mem[5]), 32'd0);

        // 6. Phase wrap: inc 0xFF8000 from phase 0 -> addresses 0,511,510
        gate = 4'b0001;
        set_inc(0, 24'hFF8000);
        for (int i = 0; i < 3; i++) begin
            do_tick();
            wait_done();
        end

        // Reset mid-sample: no sample_valid, state back to idle
        chk_addr = 1'b0;
        v0 = n_valid;
        @(posedge clk); #1;
        sample_tick = 1'b1;
        @(posedge clk); #1;
        sample_tick = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        for (int v = 0; v < NV; v++) begin
            phase_m[v] = '0;
            inc_m[v] = '0;
        end
        repeat (12) @(posedge clk);
        @(negedge clk);
        chk("no_valid_after_abort", 32'(n_valid - v0), 32'd0);
        chk("busy_after_abort", 32'(busy), 32'd0);
        chk("ld_ready_after_abort", 32'(ld_ready), 32'd1);
        chk_addr = 1'b1;

        // Recovery sample after abort: phases restart at 0
        gate = 4'b0001;
        do_tick(); wait_done();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
